pri_decoder_seq: RTL

Sequential 2-to-4 decoder that converts a 2-bit priority code back into a one-hot line. It is the receive-side counterpart of the 4x2 priority encoder. A code is accepted through a valid/ready handshake, driven as a registered one-hot output for a programmable number of cycles, and then released with a one-cycle completion pulse. It sits downstream of the encoder, wherever an encoded request index has to re-select one of four targets.

---
 rtl/pri_decoder_seq.sv | 137 +++++++++++++
 1 files changed

// File: rtl/pri_decoder_seq.sv
// pri_decoder_seq
//   Sequential 2-to-4 decoder: accepts a 2-bit code through a valid/ready
//   handshake, drives the registered one-hot decode for HOLD_CYCLES cycles,
//   then pulses done for one cycle while the outputs are cleared (GAP) before
//   returning to IDLE.
//
//   Parameters:
//     HOLD_CYCLES  cycles the one-hot output is held per code (1..255)
//     CNT_W        hold counter width, 2**CNT_W > HOLD_CYCLES
//   Ports:
//     clk          rising-edge clock
//     rst_n        asynchronous active-low reset
//     in_valid     y carries a code
//     in_ready     block can accept a code this cycle (state == IDLE)
//     y            encoded index, 00 -> bit0 ... 11 -> bit3
//     out_onehot   registered one-hot decode, 0000 when not holding
//     out_valid    out_onehot is driving a decoded code
//     done         one-cycle pulse when a hold completes
//     drop_cnt     saturating count of cycles with in_valid=1, in_ready=0
//
//   Build option:
//     PRIDEC_DROPCNT_EN  defined: drop counter implemented;
//                        undefined: drop_cnt tied to 8'd0.
module pri_decoder_seq #(
    parameter int unsigned HOLD_CYCLES = 4,
    parameter int unsigned CNT_W       = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [1:0] y,
    output logic [3:0] out_onehot,
    output logic       out_valid,
    output logic       done,
    output logic [7:0] drop_cnt
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        GAP  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       onehot_q, onehot_d;
    logic             valid_q, valid_d;
    logic             done_q, done_d;

    // Moore ready: depends on state only, never on in_valid.
    assign in_ready   = (state_q == IDLE);
    assign out_onehot = onehot_q;
    assign out_valid  = valid_q;
    assign done       = done_q;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        onehot_d = onehot_q;
        valid_d  = valid_q;
        done_d   = 1'b0;
        case (state_q)
            IDLE: begin
                onehot_d = '0;
                valid_d  = 1'b0;
                if (in_valid) begin
                    onehot_d = 4'b0001 << y;
                    valid_d  = 1'b1;
                    cnt_d    = CNT_W'(HOLD_CYCLES - 1);
                    state_d  = HOLD;
                end
            end
            HOLD: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    onehot_d = '0;
                    valid_d  = 1'b0;
                    done_d   = 1'b1;
                    state_d  = GAP;
                end
            end
            GAP: begin
                onehot_d = '0;
                valid_d  = 1'b0;
                state_d  = IDLE;
            end
            default: begin
                onehot_d = '0;
                valid_d  = 1'b0;
                cnt_d    = '0;
                state_d  = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            onehot_q <= '0;
            valid_q  <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            onehot_q <= onehot_d;
            valid_q  <= valid_d;
            done_q   <= done_d;
        end
    end

`ifdef PRIDEC_DROPCNT_EN
    logic [7:0] drop_q, drop_d;

    always_comb begin
        drop_d = drop_q;
        if (in_valid && !in_ready && (drop_q != 8'hFF)) begin
            drop_d = drop_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_q <= '0;
        end else begin
            drop_q <= drop_d;
        end
    end

    assign drop_cnt = drop_q;
`else
    assign drop_cnt = 8'd0;
`endif

endmodule
